rv32_mem_responder: RTL and testbench

//   Bus responder (slave end) for the core's instr/data request handshakes; generates instr_ready/data_ready.

---
 rtl/rv32_mem_responder.sv | 149 ++++++++++++++
 tb/tb_rv32_mem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mem_responder.sv
// Responder for the core's instr/data request handshakes, sharing one single-port synchronous SRAM.
// Define RV32_MEM_ROUND_ROBIN_EN for round-robin arbitration; otherwise the data port has fixed priority.
module rv32_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           instr_address_in,
  input  logic                  instr_read_in,
  output logic [31:0]           instr_read_value_out,
  output logic                  instr_ready_out,
  input  logic [31:0]           data_address_in,
  input  logic                  data_read_in,
  input  logic                  data_write_in,
  input  logic [3:0]            data_write_mask_in,
  input  logic [31:0]           data_write_value_in,
  output logic [31:0]           data_read_value_out,
  output logic                  data_ready_out,
  output logic [ADDR_WIDTH-1:0] mem_address_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic [3:0]            mem_write_mask_out,
  output logic [31:0]           mem_write_value_out,
  input  logic [31:0]           mem_read_value_in
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_RESP
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  gnt_data_q, gnt_data_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            mask_q, mask_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  take_data;
  logic                  req_data;

  // Byte-offset bits and bits above the SRAM range are intentionally dropped (addresses alias).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_address_in[1:0], instr_address_in[31:ADDR_WIDTH+2],
                              data_address_in[1:0], data_address_in[31:ADDR_WIDTH+2]};

  assign req_data = data_read_in | data_write_in;

`ifdef RV32_MEM_ROUND_ROBIN_EN
  // last_grant: 1 = data port, 0 = instr port
  logic last_grant_q, last_grant_d;

  always_comb begin
    if (req_data && instr_read_in) take_data = ~last_grant_q;
    else                           take_data = req_data;
  end
`else
  always_comb begin
    take_data = req_data;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_data_d = gnt_data_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    wdata_d    = wdata_q;
`ifdef RV32_MEM_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_data || instr_read_in) begin
          gnt_data_d = take_data;
          is_write_d = take_data & data_write_in;
          addr_d     = take_data ? data_address_in[ADDR_WIDTH+1:2]
                                 : instr_address_in[ADDR_WIDTH+1:2];
          mask_d     = (take_data && data_write_in) ? data_write_mask_in  : '0;
          wdata_d    = (take_data && data_write_in) ? data_write_value_in : '0;
`ifdef RV32_MEM_ROUND_ROBIN_EN
          last_grant_d = take_data;
`endif
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ISSUE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gnt_data_q <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_data_q <= gnt_data_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      wdata_q    <= wdata_d;
    end
  end

`ifdef RV32_MEM_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= 1'b0;
    else          last_grant_q <= last_grant_d;
  end
`endif

  // Outputs decode straight from registered state so async reset clears them in the same cycle.
  always_comb begin
    mem_address_out     = addr_q;
    mem_write_mask_out  = mask_q;
    mem_write_value_out = wdata_q;
    mem_read_out        = (state_q == S_ISSUE) && !is_write_q;
    mem_write_out       = (state_q == S_ISSUE) &&  is_write_q;
    instr_ready_out     = (state_q == S_RESP) && !gnt_data_q;
    data_ready_out      = (state_q == S_RESP) &&  gnt_data_q;
    instr_read_value_out = instr_ready_out ? mem_read_value_in : '0;
    data_read_value_out  = (data_ready_out && !is_write_q) ? mem_read_value_in : '0;
  end

endmodule

// File: tb/tb_rv32_mem_responder.sv
// Directed self-checking bench for rv32_mem_responder with a behavioural byte-masked SRAM.
module tb_rv32_mem_responder;
  localparam int unsigned AW = 10;
  localparam int unsigned WS = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   instr_address_in = '0;
  logic          instr_read_in = 1'b0;
  logic [31:0]   instr_read_value_out;
  logic          instr_ready_out;
  logic [31:0]   data_address_in = '0;
  logic          data_read_in = 1'b0;
  logic          data_write_in = 1'b0;
  logic [3:0]    data_write_mask_in = '0;
  logic [31:0]   data_write_value_in = '0;
  logic [31:0]   data_read_value_out;
  logic          data_ready_out;
  logic [AW-1:0] mem_address_out;
  logic          mem_read_out;
  logic          mem_write_out;
  logic [3:0]    mem_write_mask_out;
  logic [31:0]   mem_write_value_out;
  logic [31:0]   mem_read_value_in = '0;

  rv32_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .instr_address_in     (instr_address_in),
    .instr_read_in        (instr_read_in),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .data_address_in      (data_address_in),
    .data_read_in         (data_read_in),
    .data_write_in        (data_write_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_write_value_in  (data_write_value_in),
    .data_read_value_out  (data_read_value_out),
    .data_ready_out       (data_ready_out),
    .mem_address_out      (mem_address_out),
    .mem_read_out         (mem_read_out),
    .mem_write_out        (mem_write_out),
    .mem_write_mask_out   (mem_write_mask_out),
    .mem_write_value_out  (mem_write_value_out),
    .mem_read_value_in    (mem_read_value_in)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  int          rd_strobes = 0, wr_strobes = 0;
  int          instr_pulses = 0, data_pulses = 0;
  logic [31:0] last_addr = '0;
  int          checks = 0, failures = 0;

  // SRAM model: synchronous read, byte-masked write
  always @(posedge clk) begin
    if (mem_read_out) mem_read_value_in = mem[mem_address_out];
    if (mem_write_out)
      for (int b = 0; b < 4; b++)
        if (mem_write_mask_out[b]) mem[mem_address_out][b*8 +: 8] = mem_write_value_out[b*8 +: 8];
  end

  always @(negedge clk) begin
    if (instr_ready_out) instr_pulses++;
    if (data_ready_out)  data_pulses++;
    if (mem_read_out)  rd_strobes++;
    if (mem_write_out) wr_strobes++;
    if (mem_read_out || mem_write_out) last_addr = 32'(mem_address_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input bit on_data, output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (on_data ? data_ready_out : instr_ready_out) begin
        lat = c;
        break;
      end
    end
  endtask

  int lat, ip0, dp0, rs0, ws0;
  bit first_data;

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem[3] = 32'hDEADBEEF;
    mem[4] = 32'hAAAAAAAA;
`ifdef RV32_MEM_ROUND_ROBIN_EN
    first_data = 1'b0;
`else
    first_data = 1'b1;
`endif

    // Reset state
    #7;
    chk("rst_instr_ready", 32'(instr_ready_out), 32'd0);
    chk("rst_data_ready", 32'(data_ready_out), 32'd0);
    chk("rst_mem_rd_wr", {30'd0, mem_read_out, mem_write_out}, 32'd0);
    chk("rst_mem_addr", 32'(mem_address_out), 32'd0);
    chk("rst_wmask_wval", mem_write_value_out | 32'(mem_write_mask_out), 32'd0);
    chk("rst_read_values", instr_read_value_out | data_read_value_out, 32'd0);
    reset_n = 1'b1;
    step();

    // Instruction fetch of word 3
    instr_address_in = 32'h0000_000C; instr_read_in = 1'b1;
    wait_ready(1'b0, lat);
    chk("fetch_latency", 32'(lat), 32'(WS + 2));
    chk("fetch_value", instr_read_value_out, 32'hDEADBEEF);
    chk("fetch_no_data_ready", 32'(data_ready_out), 32'd0);
    instr_read_in = 1'b0;
    step();
    chk("idle_value_zero", instr_read_value_out, 32'd0);

    // Partial store then load back
    ws0 = wr_strobes;
    data_address_in = 32'h10; data_write_in = 1'b1;
    data_write_mask_in = 4'b0011; data_write_value_in = 32'h12345678;
    wait_ready(1'b1, lat);
    chk("store_latency", 32'(lat), 32'(WS + 2));
    chk("store_returns_zero", data_read_value_out, 32'd0);
    chk("store_no_instr_ready", 32'(instr_ready_out), 32'd0);
    data_write_in = 1'b0;
    step();
    chk("store_one_strobe", 32'(wr_strobes - ws0), 32'd1);
    chk("store_sram_word", mem[4], 32'hAAAA5678);
    data_read_in = 1'b1;
    wait_ready(1'b1, lat);
    chk("load_latency", 32'(lat), 32'(WS + 2));
    chk("load_value", data_read_value_out, 32'hAAAA5678);
    data_read_in = 1'b0;
    step();

    // Simultaneous instr + data read
    ip0 = instr_pulses; dp0 = data_pulses;
    instr_address_in = 32'h0C; instr_read_in = 1'b1;
    data_address_in = 32'h10; data_read_in = 1'b1;
    wait_ready(first_data, lat);
    chk("arb_first_latency", 32'(lat), 32'(WS + 2));
    chk("arb_first_value", first_data ? data_read_value_out : instr_read_value_out,
        first_data ? 32'hAAAA5678 : 32'hDEADBEEF);
    chk("arb_first_other_idle", 32'(first_data ? instr_ready_out : data_ready_out), 32'd0);
    if (first_data) data_read_in = 1'b0; else instr_read_in = 1'b0;
    wait_ready(!first_data, lat);
    chk("arb_second_latency", 32'(lat), 32'(WS + 3));
    chk("arb_second_value", first_data ? instr_read_value_out : data_read_value_out,
        first_data ? 32'hDEADBEEF : 32'hAAAA5678);
    instr_read_in = 1'b0; data_read_in = 1'b0;
    step();
    chk("arb_pulses", 32'((instr_pulses - ip0) * 16 + (data_pulses - dp0)), 32'h11);

    // Fetch dropped during ISSUE still completes once
    ip0 = instr_pulses; dp0 = data_pulses;
    instr_address_in = 32'h0C; instr_read_in = 1'b1;
    repeat (WS + 1) step();
    chk("drop_issue_strobe", 32'(mem_read_out), 32'd1);
    instr_read_in = 1'b0;
    wait_ready(1'b0, lat);
    chk("drop_latency", 32'(lat), 32'd1);
    chk("drop_value", instr_read_value_out, 32'hDEADBEEF);
    repeat (6) step();
    chk("drop_instr_pulses", 32'(instr_pulses - ip0), 32'd1);
    chk("drop_data_pulses", 32'(data_pulses - dp0), 32'd0);

    // Reset asserted during WAIT
    data_address_in = 32'h0C; data_read_in = 1'b1;
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_addr", 32'(mem_address_out), 32'd0);
    chk("midrst_strobes_ready", {28'd0, mem_read_out, mem_write_out, data_ready_out, instr_ready_out}, 32'd0);
    chk("midrst_value", data_read_value_out, 32'd0);
    #2 reset_n = 1'b1;
    wait_ready(1'b1, lat);
    chk("postrst_latency", 32'(lat), 32'(WS + 2));
    chk("postrst_value", data_read_value_out, 32'hDEADBEEF);
    data_read_in = 1'b0;
    step();

    // Aliased address, held request re-served
    instr_address_in = 32'h0000_100C; instr_read_in = 1'b1;
    wait_ready(1'b0, lat);
    chk("alias_latency", 32'(lat), 32'(WS + 2));
    chk("alias_value", instr_read_value_out, 32'hDEADBEEF);
    chk("alias_word", last_addr, 32'd3);
    wait_ready(1'b0, lat);
    chk("reserve_latency", 32'(lat), 32'(WS + 3));
    instr_read_in = 1'b0;
    step();

    // Misaligned load reads enclosing word
    data_address_in = 32'h0E; data_read_in = 1'b1;
    wait_ready(1'b1, lat);
    chk("misalign_value", data_read_value_out, 32'hDEADBEEF);
    chk("misalign_word", last_addr, 32'd3);
    data_read_in = 1'b0;
    step();

    // Read and write both high acts as a full store
    rs0 = rd_strobes; ws0 = wr_strobes;
    data_address_in = 32'h14; data_read_in = 1'b1; data_write_in = 1'b1;
    data_write_mask_in = 4'b1111; data_write_value_in = 32'h55AA33CC;
    wait_ready(1'b1, lat);
    chk("rw_store_value", data_read_value_out, 32'd0);
    data_write_in = 1'b0; data_read_in = 1'b0;
    step();
    chk("rw_strobes", 32'((wr_strobes - ws0) * 16 + (rd_strobes - rs0)), 32'h10);
    data_read_in = 1'b1;
    wait_ready(1'b1, lat);
    chk("rw_readback", data_read_value_out, 32'h55AA33CC);
    data_read_in = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
